// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stall and operand-forwarding control for a five-stage MIPS pipeline.
// Ports:
//   clk, reset                 pipeline clock, synchronous active-high reset
//   A1, A2, A3, RegWrite       D-stage rs/rt/destination addresses and write enable
//   tuse_rs, tuse_rt, tnew     D-stage operand use times and result-ready time
//   stall                      freeze PC and F/D, inject a bubble into D/E
//   fwd_d_rs, fwd_d_rt         D operand source: 0 RF, 1 E, 2 M, 3 W
//   fwd_e_rs, fwd_e_rt         E operand source: 0 pipelined, 1 M, 2 W
//   stall_cnt                  stalled cycles since reset, wrapping
module hazard_scoreboard (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [4:0]  A3,
    input  logic        RegWrite,
    input  logic [2:0]  tuse_rs,
    input  logic [2:0]  tuse_rt,
    input  logic [2:0]  tnew,
    output logic        stall,
    output logic [1:0]  fwd_d_rs,
    output logic [1:0]  fwd_d_rt,
    output logic [1:0]  fwd_e_rs,
    output logic [1:0]  fwd_e_rt,
    output logic [31:0] stall_cnt
);
    logic [4:0] dst_e, dst_m, dst_w, rs_e, rt_e, dst_d;
    logic [2:0] tn_e, tn_m, tn_w, tn_rs, tn_rt;
    logic [1:0] sel_rs, sel_rt;
    logic       stall_rs, stall_rt;

    // Youngest stage holding address a: 1 = E, 2 = M, 3 = W, 0 = none; $0 never matches.
    function automatic logic [1:0] youngest(input logic [4:0] a, de, dm, dw);
        return (a == 5'd0) ? 2'd0 : (de == a) ? 2'd1 : (dm == a) ? 2'd2 : (dw == a) ? 2'd3 : 2'd0;
    endfunction

    function automatic logic [2:0] dec_sat(input logic [2:0] x);
        return (x == 3'd0) ? 3'd0 : x - 3'd1;
    endfunction

    always_comb begin
        sel_rs   = youngest(A1, dst_e, dst_m, dst_w);
        sel_rt   = youngest(A2, dst_e, dst_m, dst_w);
        tn_rs    = (sel_rs == 2'd1) ? tn_e : (sel_rs == 2'd2) ? tn_m : (sel_rs == 2'd3) ? tn_w : 3'd0;
        tn_rt    = (sel_rt == 2'd1) ? tn_e : (sel_rt == 2'd2) ? tn_m : (sel_rt == 2'd3) ? tn_w : 3'd0;
        stall_rs = (sel_rs != 2'd0) && (tn_rs > tuse_rs);
        stall_rt = (sel_rt != 2'd0) && (tn_rt > tuse_rt);
    end

    assign dst_d    = RegWrite ? A3 : 5'd0;
    assign stall    = stall_rs | stall_rt;
    // A producer still computing yields 0 here: either stall is up or D does not need the value yet.
    assign fwd_d_rs = (sel_rs != 2'd0 && tn_rs == 3'd0) ? sel_rs : 2'd0;
    assign fwd_d_rt = (sel_rt != 2'd0 && tn_rt == 3'd0) ? sel_rt : 2'd0;
    assign fwd_e_rs = (rs_e != 5'd0 && rs_e == dst_m && tn_m == 3'd0) ? 2'd1 :
                      (rs_e != 5'd0 && rs_e == dst_w) ? 2'd2 : 2'd0;
    assign fwd_e_rt = (rt_e != 5'd0 && rt_e == dst_m && tn_m == 3'd0) ? 2'd1 :
                      (rt_e != 5'd0 && rt_e == dst_w) ? 2'd2 : 2'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            dst_e     <= 5'd0;
            tn_e      <= 3'd0;
            rs_e      <= 5'd0;
            rt_e      <= 5'd0;
            dst_m     <= 5'd0;
            tn_m      <= 3'd0;
            dst_w     <= 5'd0;
            tn_w      <= 3'd0;
            stall_cnt <= 32'd0;
        end else begin
            dst_e     <= stall ? 5'd0 : dst_d;
            tn_e      <= stall ? 3'd0 : dec_sat(tnew);
            rs_e      <= stall ? 5'd0 : A1;
            rt_e      <= stall ? 5'd0 : A2;
            dst_m     <= dst_e;
            tn_m      <= dec_sat(tn_e);
            dst_w     <= dst_m;
            tn_w      <= dec_sat(tn_m);
            stall_cnt <= stall_cnt + {31'd0, stall};
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic against a history-based pipeline model.
module tb_hazard_scoreboard;
    localparam int N = 8192;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2, A3;
    logic        RegWrite;
    logic [2:0]  tuse_rs, tuse_rt, tnew;
    logic        stall;
    logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
    logic [31:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .A3(A3), .RegWrite(RegWrite),
        .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .tnew(tnew), .stall(stall),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Model: one entry per cycle recording what entered E at that edge (bubble = dst 0).
    // The instruction in E/M/W at cycle t is the one issued at t-1/t-2/t-3, and its
    // result is ready at absolute cycle issue + tnew.
    logic [4:0]  h_dst [N];
    logic [4:0]  h_rs  [N];
    logic [4:0]  h_rt  [N];
    int          h_rdy [N];
    int          t;
    logic [31:0] m_cnt;
    logic        exp_stall;
    logic [1:0]  exp_fdrs, exp_fdrt, exp_fers, exp_fert;

    function automatic int tn_of(input int i);
        return (h_rdy[i] > t) ? h_rdy[i] - t : 0;
    endfunction

    function automatic int youngest(input logic [4:0] a);
        for (int k = 1; k <= 3; k++)
            if (a != 5'd0 && h_dst[t-k] == a) return k;
        return 0;
    endfunction

    function automatic logic [1:0] e_src(input logic [4:0] a);
        if (a == 5'd0) return 2'd0;
        if (h_dst[t-2] == a && tn_of(t-2) == 0) return 2'd1;
        if (h_dst[t-3] == a) return 2'd2;
        return 2'd0;
    endfunction

    task automatic bubble(input int i);
        h_dst[i] = 5'd0;
        h_rs[i]  = 5'd0;
        h_rt[i]  = 5'd0;
        h_rdy[i] = 0;
    endtask

    task automatic eval_model();
        int kr, kt;
        kr = youngest(A1);
        kt = youngest(A2);
        exp_stall = (kr != 0 && tn_of(t-kr) > int'(tuse_rs)) || (kt != 0 && tn_of(t-kt) > int'(tuse_rt));
        exp_fdrs  = (kr != 0 && tn_of(t-kr) == 0) ? 2'(kr) : 2'd0;
        exp_fdrt  = (kt != 0 && tn_of(t-kt) == 0) ? 2'(kt) : 2'd0;
        exp_fers  = e_src(h_rs[t-1]);
        exp_fert  = e_src(h_rt[t-1]);
    endtask

    task automatic tick();
        eval_model();
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 3; k++) bubble(t-k);
            m_cnt = 32'd0;
        end else begin
            if (exp_stall) bubble(t);
            else begin
                h_dst[t] = RegWrite ? A3 : 5'd0;
                h_rs[t]  = A1;
                h_rt[t]  = A2;
                h_rdy[t] = t + int'(tnew);
            end
            m_cnt = m_cnt + {31'd0, exp_stall};
        end
        t++;
        #1;
    endtask

    task automatic set_d(input logic [4:0] a1, a2, a3, input logic rw, input logic [2:0] ur, ut, tn);
        A1 = a1; A2 = a2; A3 = a3; RegWrite = rw; tuse_rs = ur; tuse_rt = ut; tnew = tn;
    endtask

    task automatic flush();
        set_d(0, 0, 0, 0, 6, 6, 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_d(8, 8, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt} !== 9'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=000000000", {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt});
        end
        checks++;
        if (stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        tick();
    endtask

    task automatic test_lw_use();
        logic [31:0] c0;
        flush();
        c0 = stall_cnt;
        set_d(0, 0, 8, 1, 6, 6, 3);
        tick();
        set_d(8, 0, 9, 1, 1, 6, 2);
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL lw_use_stall got=%b exp=1", stall); end
        tick();
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL lw_use_release got=%b exp=0", stall); end
        checks++;
        if (fwd_d_rs !== 2'd0) begin failures++; $display("FAIL lw_use_fwd_d got=%0d exp=0", fwd_d_rs); end
        tick();
        set_d(0, 0, 0, 0, 6, 6, 0);
        @(negedge clk);
        checks++;
        if (fwd_e_rs !== 2'd2) begin failures++; $display("FAIL lw_use_fwd_e got=%0d exp=2", fwd_e_rs); end
        checks++;
        if (stall_cnt - c0 !== 32'd1) begin failures++; $display("FAIL lw_use_cnt got=%0d exp=1", stall_cnt - c0); end
        tick();
    endtask

    task automatic test_alu_beq();
        logic [31:0] c0;
        flush();
        c0 = stall_cnt;
        set_d(0, 0, 9, 1, 6, 6, 2);
        tick();
        set_d(9, 0, 0, 0, 0, 6, 0);
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL alu_beq_stall got=%b exp=1", stall); end
        tick();
        @(negedge clk);
        checks++;
        if ({stall, fwd_d_rs} !== 3'b010) begin failures++; $display("FAIL alu_beq_fwd got=%b exp=010", {stall, fwd_d_rs}); end
        tick();
        checks++;
        if (stall_cnt - c0 !== 32'd1) begin failures++; $display("FAIL alu_beq_cnt got=%0d exp=1", stall_cnt - c0); end
    endtask

    task automatic test_lw_beq();
        logic [31:0] c0;
        flush();
        c0 = stall_cnt;
        set_d(0, 0, 8, 1, 6, 6, 3);
        tick();
        set_d(8, 0, 0, 0, 0, 6, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (stall !== 1'b1) begin failures++; $display("FAIL lw_beq_stall%0d got=%b exp=1", i, stall); end
            tick();
        end
        @(negedge clk);
        checks++;
        if ({stall, fwd_d_rs} !== 3'b011) begin failures++; $display("FAIL lw_beq_fwd got=%b exp=011", {stall, fwd_d_rs}); end
        tick();
        checks++;
        if (stall_cnt - c0 !== 32'd2) begin failures++; $display("FAIL lw_beq_cnt got=%0d exp=2", stall_cnt - c0); end
    endtask

    task automatic test_jal_jr();
        flush();
        set_d(0, 0, 31, 1, 6, 6, 1);
        tick();
        set_d(31, 0, 0, 0, 0, 6, 0);
        @(negedge clk);
        checks++;
        if ({stall, fwd_d_rs} !== 3'b001) begin failures++; $display("FAIL jal_jr got=%b exp=001", {stall, fwd_d_rs}); end
        tick();
    endtask

    task automatic test_zero_reg();
        flush();
        set_d(0, 0, 0, 1, 6, 6, 3);
        tick();
        set_d(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({stall, fwd_d_rs, fwd_d_rt} !== 5'd0) begin
            failures++;
            $display("FAIL zero_reg got=%b exp=00000", {stall, fwd_d_rs, fwd_d_rt});
        end
        tick();
    endtask

    task automatic test_dual();
        logic [31:0] c0;
        flush();
        c0 = stall_cnt;
        set_d(0, 0, 8, 1, 6, 6, 3);
        tick();
        set_d(0, 0, 9, 1, 6, 6, 2);
        tick();
        set_d(9, 8, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL dual_stall got=%b exp=1", stall); end
        tick();
        @(negedge clk);
        checks++;
        if ({stall, fwd_d_rs, fwd_d_rt} !== 5'b01011) begin
            failures++;
            $display("FAIL dual_fwd got=%b exp=01011", {stall, fwd_d_rs, fwd_d_rt});
        end
        tick();
        checks++;
        if (stall_cnt - c0 !== 32'd1) begin failures++; $display("FAIL dual_cnt got=%0d exp=1", stall_cnt - c0); end
    endtask

    task automatic test_back_to_back();
        reset = 1'b1;
        set_d(0, 0, 0, 0, 6, 6, 0);
        tick();
        reset = 1'b0;
        for (int p = 0; p < 2; p++) begin
            set_d(0, 0, 5'(8 + 2 * p), 1, 6, 6, 3);
            tick();
            set_d(5'(8 + 2 * p), 0, 12, 1, 1, 6, 2);
            tick();
            tick();
        end
        set_d(0, 0, 0, 0, 6, 6, 0);
        @(negedge clk);
        checks++;
        if (stall_cnt !== 32'd2) begin failures++; $display("FAIL back_to_back_cnt got=%0d exp=2", stall_cnt); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        flush();
        set_d(0, 0, 8, 1, 6, 6, 3);
        tick();
        set_d(8, 0, 0, 0, 0, 6, 0);
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL mid_stall_pre got=%b exp=1", stall); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall, stall_cnt} !== 33'd0) begin
            failures++;
            $display("FAIL mid_stall_reset got stall=%b cnt=%0d exp stall=0 cnt=0", stall, stall_cnt);
        end
        tick();
    endtask

    task automatic test_wrap();
        flush();
        set_d(0, 0, 8, 1, 6, 6, 3);
        tick();
        set_d(8, 0, 9, 1, 1, 6, 2);
        @(negedge clk);
        force dut.stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt;
        m_cnt = 32'hFFFF_FFFF;
        tick();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 32'd0) begin failures++; $display("FAIL wrap_cnt got=%0h exp=0", stall_cnt); end
        tick();
    endtask

    task automatic test_random();
        logic [2:0] tu [4] = '{3'd0, 3'd1, 3'd2, 3'd6};
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            if (!exp_stall)
                set_d(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), tu[$urandom_range(0, 3)], tu[$urandom_range(0, 3)],
                      3'($urandom_range(0, 3)));
            @(negedge clk);
            eval_model();
            checks++;
            if (stall !== exp_stall) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, stall, exp_stall); end
            checks++;
            if ({fwd_d_rs, fwd_d_rt} !== {exp_fdrs, exp_fdrt}) begin
                failures++;
                $display("FAIL rnd_fwd_d cyc=%0d got=%0d/%0d exp=%0d/%0d", i, fwd_d_rs, fwd_d_rt, exp_fdrs, exp_fdrt);
            end
            checks++;
            if ({fwd_e_rs, fwd_e_rt} !== {exp_fers, exp_fert}) begin
                failures++;
                $display("FAIL rnd_fwd_e cyc=%0d got=%0d/%0d exp=%0d/%0d", i, fwd_e_rs, fwd_e_rt, exp_fers, exp_fert);
            end
            checks++;
            if (stall_cnt !== m_cnt) begin failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, stall_cnt, m_cnt); end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        t = 3;
        m_cnt = 32'd0;
        exp_stall = 1'b0;
        for (int i = 0; i < N; i++) bubble(i);
        reset = 1'b0;
        set_d(0, 0, 0, 0, 6, 6, 0);
        #1;
        test_reset();
        test_lw_use();
        test_alu_beq();
        test_lw_beq();
        test_jal_jr();
        test_zero_reg();
        test_dual();
        test_back_to_back();
        test_reset_mid_stall();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Hazard and forwarding controller for the five-stage MIPS pipeline, sitting directly downstream of the D-stage instruction decoder. It consumes the decoder's register addresses, write enable and Tuse/Tnew encodings. It keeps a shadow copy of the destination register and remaining Tnew for the E, M and W stages. From that state it drives the pipeline stall and the operand-forwarding selects for the D and E stages.

## Interface
- No parameters.
- `clk`  in  1  single pipeline clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all shadow state on the next rising edge.
- `A1`  in  5  D-stage rs address (instr[25:21]).
- `A2`  in  5  D-stage rt address (instr[20:16]).
- `A3`  in  5  D-stage destination address; 0 = no write.
- `RegWrite`  in  1  D-stage instruction writes the register file.
- `tuse_rs`, `tuse_rt`  in  3  cycles after D until the operand is consumed: 0 = D, 1 = E, 2 = M, 6 = unused.
- `tnew`  in  3  cycles after D until the result exists: 3 = lw, 2 = ALU, 1 = link, 0 = none.
- `stall`  out  1  freezes PC and the F/D register, and injects a bubble into D/E.
- `fwd_d_rs`, `fwd_d_rt`  out  2  D-stage operand source: 0 = RF, 1 = E, 2 = M, 3 = W.
- `fwd_e_rs`, `fwd_e_rt`  out  2  E-stage operand source: 0 = pipelined value, 1 = M, 2 = W.
- `stall_cnt`  out  32  count of stalled cycles since reset.

## Operation
- Shadow registers per stage S in {E, M, W}: `dst_S` (5), `tn_S` (3). E also holds `rs_E` and `rt_E` (5 each).
- Effective D destination: `dst_D = RegWrite ? A3 : 0`. A destination of 0 never matches.
- Each edge, when not in reset:
  - If `stall`: E loads a bubble (dst 0, tn 0, rs 0, rt 0).
  - Otherwise E loads `dst_D`, `sat(tnew-1)`, `A1`, `A2`.
  - M loads `dst_E` and `sat(tn_E-1)`.
  - W loads `dst_M` and `sat(tn_M-1)`.
  - `sat(x-1)` floors at 0. M and W always advance, stall or not.
- Stall rule for operand address A with use time T, evaluated combinationally from current state:
  - Find the youngest stage (E, then M, then W) with `dst_S == A` and `A != 0`.
  - Stall if that stage has `tn_S > T`.
  - `stall` = rs check (A1, tuse_rs) OR rt check (A2, tuse_rt).
  - T = 6 never stalls, since Tnew is at most 2 in shadow state.
- D forwarding: take the youngest matching stage. If its `tn_S == 0`, select 1/2/3 for E/M/W; otherwise select 0. In the otherwise case `stall` is asserted or the operand is not needed in D.
- E forwarding for `rs_E` and `rt_E`:
  - 1 if `dst_M` matches and `tn_M == 0`.
  - Else 2 if `dst_W` matches.
  - Else 0.
  - M has priority over W. A zero address always gives 0.
- `stall_cnt` increments by 1 each edge where `stall` = 1 and `reset` = 0. It wraps from 0xFFFFFFFF to 0.
- All outputs other than `stall_cnt` are combinational from inputs plus state. No output registering adds latency.

## Timing
- Reset: after the reset edge all dst, tn, rs and rt are 0 and `stall_cnt` = 0. With zero state, `stall` = 0 and every fwd output = 0 regardless of D inputs.
- Reset asserted mid-stall wins over the stall: the state clears, and on the following cycle `stall` = 0 unless new D inputs cause a hazard.
- lw followed by a dependent ALU op: exactly 1 stall cycle.
- lw followed by a dependent beq: exactly 2 stall cycles.
- ALU op followed by a dependent beq: exactly 1 stall cycle.
- While stalled, the D inputs stay constant (F/D frozen) and are re-evaluated each cycle against the advancing shadow state.
- Simultaneous rs and rt hazards produce one stall signal. The cycle count equals the longer of the two.

## Test plan
- Reset: hold `reset` 2 cycles with A1=A2=8 and tuse 0 -> `stall`=0, all fwd=0, `stall_cnt`=0.
- lw $8 (RegWrite=1, A3=8, tnew=3), then addu with A1=8, tuse_rs=1 -> `stall`=1 for 1 cycle; next cycle `fwd_d_rs`=0; E-stage addu sees `fwd_e_rs`=2 (W).
- addu $9, then beq with A1=9, tuse_rs=0 -> 1 stall; next cycle `fwd_d_rs`=2 (M).
- jal (A3=31, tnew=1), then jr with A1=31, tuse 0 -> no stall, `fwd_d_rs`=1 (E).
- Write to $0 (A3=0, RegWrite=1, tnew=3), then a reader of $0 -> no stall, fwd=0.
- Two back-to-back lw-use pairs -> `stall_cnt`=2. Preload the counter near wrap in a forced test -> wraps to 0.
